// File: rtl/fp_mul_result_stage.sv
// Result stage behind an FP32 multiplier: classifies exceptions into {NV,OF,UF},
// buffers results in a 2-entry FIFO and keeps sticky flags plus an accepted-result count.
module fp_mul_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  input  logic [31:0] fp_Z,
  input  logic        ovrf,
  input  logic        udrf,
  input  logic        nan,
  input  logic        inf,
  input  logic        zer,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_Z,
  output logic [2:0]  out_flags,
  output logic [2:0]  fflags,
  input  logic        flags_clr,
  output logic [15:0] op_cnt
);

  localparam logic [31:0] CanonNan = 32'h7fc00000;

  logic [34:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [2:0]  fflags_q, fflags_d;
  logic [15:0] op_cnt_q, op_cnt_d;
  logic        ready_en_q;

  logic [7:0]  x_exp, y_exp;
  logic [22:0] x_frac, y_frac;
  logic        snan_x, snan_y, inf_x, inf_y, bad_rm;
  logic        nv, of, uf;
  logic [34:0] new_entry, head;
  logic        push, pop;

  // Sign bits and the inf/zer hints play no part in the flag classification.
  logic unused_inputs;
  assign unused_inputs = ^{fp_X[31], fp_Y[31], inf, zer};

  assign x_exp  = fp_X[30:23];
  assign y_exp  = fp_Y[30:23];
  assign x_frac = fp_X[22:0];
  assign y_frac = fp_Y[22:0];

  assign snan_x = (x_exp == 8'hff) && (x_frac != 23'd0) && !x_frac[22];
  assign snan_y = (y_exp == 8'hff) && (y_frac != 23'd0) && !y_frac[22];
  assign inf_x  = (x_exp == 8'hff) && (x_frac == 23'd0);
  assign inf_y  = (y_exp == 8'hff) && (y_frac == 23'd0);
  assign bad_rm = r_mode > 3'b100;

  assign nv = snan_x | snan_y | (inf_x & (y_exp == 8'h00)) | (inf_y & (x_exp == 8'h00)) | bad_rm;
  assign of = ovrf & ~nan;
  assign uf = udrf & ~nan & ~ovrf;

  assign new_entry = {(bad_rm ? CanonNan : fp_Z), nv, of, uf};

  // in_ready depends on registered state only; ready_en_q holds it low until the
  // first edge after reset release.
  assign in_ready  = ready_en_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_Z     = out_valid ? head[34:3] : 32'd0;
  assign out_flags = out_valid ? head[2:0] : 3'd0;
  assign fflags    = fflags_q;
  assign op_cnt    = op_cnt_q;

  always_comb begin
    count_d  = count_q;
    fflags_d = fflags_q;
    op_cnt_d = op_cnt_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flags_clr) begin
      fflags_d = push ? new_entry[2:0] : 3'd0;
    end else if (push) begin
      fflags_d = fflags_q | new_entry[2:0];
    end
    if (push && (op_cnt_q != 16'hffff)) begin
      op_cnt_d = op_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      fflags_q   <= 3'd0;
      op_cnt_q   <= 16'd0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
      op_cnt_q   <= op_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Randomised and directed bench for fp_mul_result_stage against a queue-based reference model.
module tb_fp_mul_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_X = '0, fp_Y = '0, fp_Z = '0;
  logic [2:0]  r_mode = '0;
  logic        ovrf = 1'b0, udrf = 1'b0, nan = 1'b0, inf = 1'b0, zer = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_Z;
  logic [2:0]  out_flags;
  logic [2:0]  fflags;
  logic        flags_clr = 1'b0;
  logic [15:0] op_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [34:0] mq[$];
  logic [2:0]  m_ff = '0;
  logic [15:0] m_cnt = '0;
  bit          m_ready_en = 1'b0;

  always #5 clk = ~clk;

  fp_mul_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .fp_Z(fp_Z),
    .ovrf(ovrf), .udrf(udrf), .nan(nan), .inf(inf), .zer(zer),
    .out_valid(out_valid), .out_ready(out_ready), .out_Z(out_Z),
    .out_flags(out_flags), .fflags(fflags), .flags_clr(flags_clr), .op_cnt(op_cnt)
  );

  function automatic logic [34:0] ref_entry(logic [31:0] x, logic [31:0] y, logic [31:0] z,
                                            logic [2:0] rm, logic ov, logic ud, logic nn);
    int unsigned xe, ye, xf, yf;
    bit snan_x, snan_y, inf_x, inf_y, e_nv, e_of, e_uf;
    logic [31:0] e_z;
    xe = (x >> 23) & 8'hff;  ye = (y >> 23) & 8'hff;
    xf = x & 32'h7fffff;     yf = y & 32'h7fffff;
    snan_x = (xe == 255) && (xf != 0) && (xf < 32'h400000);
    snan_y = (ye == 255) && (yf != 0) && (yf < 32'h400000);
    inf_x  = (xe == 255) && (xf == 0);
    inf_y  = (ye == 255) && (yf == 0);
    e_nv = snan_x || snan_y || (inf_x && ye == 0) || (inf_y && xe == 0) || (rm >= 5);
    e_of = ov && !nn;
    e_uf = ud && !nn && !ov;
    e_z  = (rm >= 5) ? 32'h7fc00000 : z;
    return {e_z, e_nv, e_of, e_uf};
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = {v[31], 8'hff, 23'd0};
      1: v = {v[31], 31'd0};
      2: v = {v[31], 8'hff, 1'b0, v[21:0] | 22'd1};
      3: v = {v[31], 8'hff, 1'b1, v[21:0]};
      4: v = {v[31], 8'h00, v[22:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic set_in(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [2:0] rm,
                        logic ov, logic ud, logic nn);
    fp_X = x; fp_Y = y; fp_Z = z; r_mode = rm; ovrf = ov; udrf = ud; nan = nn;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit do_push, do_pop;
    logic [34:0] e;
    logic [2:0]  nf;
    do_push = in_valid && m_ready_en && (mq.size() < 2);
    do_pop  = (mq.size() != 0) && out_ready;
    e = ref_entry(fp_X, fp_Y, fp_Z, r_mode, ovrf, udrf, nan);
    @(posedge clk);
    if (rst_n) begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
      nf = do_push ? e[2:0] : 3'd0;
      m_ff = flags_clr ? nf : (m_ff | nf);
      if (do_push && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      m_ready_en = 1'b1;
    end
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ff = '0;
    m_cnt = '0;
    m_ready_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    in_valid = 1'b1;
    set_in(32'h40400000, 32'h40400000, 32'h41100000, 3'd0, 1'b1, 1'b0, 1'b0);
    #2;
    checks++;
    if ({in_ready, out_valid, out_Z, out_flags, fflags, op_cnt} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b z=%h fl=%b ff=%b cnt=%0d, want all 0",
               in_ready, out_valid, out_Z, out_flags, fflags, op_cnt);
    end
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_edge: got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_in(32'h40400000, 32'h40400000, 32'h41100000, 3'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_Z !== 32'h41100000 || out_flags !== 3'd0 || op_cnt !== 16'd1) begin
      errors++;
      $display("FAIL basic_push: got vld=%b z=%h fl=%b cnt=%0d want 1 41100000 000 1",
               out_valid, out_Z, out_flags, op_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_Z !== 32'd0) begin
      errors++; $display("FAIL basic_drain: got vld=%b z=%h want 0 0", out_valid, out_Z);
    end
  endtask

  task automatic test_nv_clear();
    out_ready = 1'b1;
    set_in(32'h7f800000, 32'h00000000, 32'h7fc00000, 3'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_flags !== 3'b100 || fflags !== 3'b100 || out_Z !== 32'h7fc00000) begin
      errors++;
      $display("FAIL inf_times_zero: got fl=%b ff=%b z=%h want 100 100 7fc00000",
               out_flags, fflags, out_Z);
    end
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    checks++;
    if (fflags !== 3'd0) begin
      errors++; $display("FAIL flags_clear: got %b want 000", fflags);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    base = m_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h3f800000, 32'h3f800000, 32'h11110000 + i, 3'd0, 1'b0, 1'b0, 1'b0);
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready: got %b want 0", in_ready);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (op_cnt !== base + 16'd2 || out_Z !== 32'h11110000) begin
      errors++;
      $display("FAIL full_count: got cnt=%0d z=%h want %0d 11110000", op_cnt, out_Z, base + 2);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_Z !== 32'h11110001 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_order: got z=%h rdy=%b vld=%b want 11110001 1 1", out_Z, in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_clr_push();
    out_ready = 1'b1;
    in_valid = 1'b1;
    flags_clr = 1'b1;
    set_in(32'h00800000, 32'h00800000, 32'h00000000, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (fflags !== 3'b001) begin
      errors++; $display("FAIL uf_setup: got %b want 001", fflags);
    end
    set_in(32'h7f000000, 32'h7f000000, 32'h7f800000, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    flags_clr = 1'b0;
    checks++;
    if (fflags !== 3'b010 || out_flags !== 3'b010) begin
      errors++; $display("FAIL clr_with_push: got ff=%b fl=%b want 010 010", fflags, out_flags);
    end
    tick();
  endtask

  task automatic test_canonical_nan();
    out_ready = 1'b1;
    in_valid = 1'b1;
    set_in(32'h3f800000, 32'h40000000, 32'h40000000, 3'b101, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_Z !== 32'h7fc00000 || out_flags[2] !== 1'b1) begin
      errors++; $display("FAIL bad_rmode: got z=%h fl=%b want 7fc00000 1xx", out_Z, out_flags);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ez;
    logic [2:0]  efl;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flags_clr = ($urandom_range(0, 7) == 0);
      set_in(pick_operand(), pick_operand(), $urandom, 3'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom));
      inf = 1'($urandom);
      zer = 1'($urandom);
      tick();
      ez  = (mq.size() != 0) ? mq[0][34:3] : 32'd0;
      efl = (mq.size() != 0) ? mq[0][2:0] : 3'd0;
      checks++;
      if (out_valid !== (mq.size() != 0) || out_Z !== ez || out_flags !== efl) begin
        errors++;
        $display("FAIL rand_head[%0d]: got vld=%b z=%h fl=%b want %b %h %b",
                 i, out_valid, out_Z, out_flags, mq.size() != 0, ez, efl);
      end
      checks++;
      if (in_ready !== (mq.size() < 2) || fflags !== m_ff || op_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_state[%0d]: got rdy=%b ff=%b cnt=%0d want %b %b %0d",
                 i, in_ready, fflags, op_cnt, mq.size() < 2, m_ff, m_cnt);
      end
    end
    in_valid = 1'b0;
    flags_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_in(32'h7f800001, 32'h3f800000, 32'hdeadbeef, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_full: got rdy=%b vld=%b want 0 1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_cnt !== 16'd0 || fflags !== 3'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got vld=%b cnt=%0d ff=%b rdy=%b want 0 0 000 0",
               out_valid, op_cnt, fflags, in_ready);
    end
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_Z !== 32'd0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stale_after_reset[%0d]: got vld=%b z=%h rdy=%b want 0 0 1",
                 i, out_valid, out_Z, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nv_clear();
    test_backpressure();
    test_clr_push();
    test_canonical_nan();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
